// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage: owns the PC, the instruction-memory request and the
// IF/ID pipeline register, with stall holding and redirect squashing.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] BUBBLE_IR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        pc_redirect,
  input  logic [15:0] pc_target,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        ifid_valid,
  output logic [15:0] ifid_ir,
  output logic [15:0] ifid_pc
);

  typedef enum logic [1:0] {
    StFetch,
    StHold,
    StDiscard
  } state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] buf_q;
  logic [15:0] tgt_q;
  logic        valid_q;
  logic [15:0] ir_q;
  logic [15:0] ifpc_q;

  logic [15:0] pc_plus2;
  logic [15:0] target;

  assign pc_plus2 = pc_q + 16'd2;
  assign target   = {pc_target[15:1], 1'b0};

  // The request stays open in DISCARD on the old PC; the redirect target waits in tgt_q.
  assign imem_read    = ~reset & (state_q != StHold);
  assign imem_address = pc_q;

  assign ifid_valid = valid_q;
  assign ifid_ir    = ir_q;
  assign ifid_pc    = ifpc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      buf_q   <= 16'h0000;
      tgt_q   <= 16'h0000;
      valid_q <= 1'b0;
      ir_q    <= BUBBLE_IR;
      ifpc_q  <= 16'h0000;
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_resp) begin
            if (pc_redirect) begin
              pc_q    <= target;
              valid_q <= 1'b0;
              ir_q    <= BUBBLE_IR;
            end else if (!stall) begin
              valid_q <= 1'b1;
              ir_q    <= imem_rdata;
              ifpc_q  <= pc_plus2;
              pc_q    <= pc_plus2;
            end else begin
              buf_q   <= imem_rdata;
              state_q <= StHold;
            end
          end else if (pc_redirect) begin
            tgt_q   <= target;
            state_q <= StDiscard;
            valid_q <= 1'b0;
            ir_q    <= BUBBLE_IR;
          end else if (!stall) begin
            valid_q <= 1'b0;
            ir_q    <= BUBBLE_IR;
          end
        end

        StHold: begin
          if (pc_redirect) begin
            pc_q    <= target;
            state_q <= StFetch;
            valid_q <= 1'b0;
            ir_q    <= BUBBLE_IR;
          end else if (!stall) begin
            valid_q <= 1'b1;
            ir_q    <= buf_q;
            ifpc_q  <= pc_plus2;
            pc_q    <= pc_plus2;
            state_q <= StFetch;
          end
        end

        StDiscard: begin
          if (pc_redirect || !stall) begin
            valid_q <= 1'b0;
            ir_q    <= BUBBLE_IR;
          end
          if (imem_resp) begin
            pc_q    <= pc_redirect ? target : tgt_q;
            state_q <= StFetch;
          end else if (pc_redirect) begin
            tgt_q <= target;
          end
        end

        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage: expected instruction stream is the sequential
// program from the last redirect target, consumed whenever decode accepts IF/ID.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        pc_redirect;
  logic [15:0] pc_target;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        ifid_valid;
  logic [15:0] ifid_ir;
  logic [15:0] ifid_pc;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .imem_read   (imem_read),
    .imem_address(imem_address),
    .imem_resp   (imem_resp),
    .imem_rdata  (imem_rdata),
    .ifid_valid  (ifid_valid),
    .ifid_ir     (ifid_ir),
    .ifid_pc     (ifid_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   consumed = 0;
  int   age = 0;
  int   lat = 1;
  int   since_redirect = 0;
  bit   mon_en = 1'b0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h1261;
      16'h0002: mem_word = 16'h1262;
      16'h0010: mem_word = 16'h5020;
      16'hFFFE: mem_word = 16'h0FFF;
      default:  mem_word = (a * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Expected program from a start address: each entry is {word, address+2} with 16-bit wrap.
  task automatic restart(input logic [15:0] start);
    logic [15:0] a;
    exp_t e;
    a = start;
    sb.delete();
    for (int i = 0; i < 300; i++) begin
      e.ir = mem_word(a);
      e.pc = a + 16'd2;
      sb.push_back(e);
      a = a + 16'd2;
    end
  endtask

  task automatic drive_cycle(input int phase);
    stall       = (phase == 2) && ($urandom_range(0, 99) < 30);
    pc_redirect = 1'b0;
    if (phase == 2 && ($urandom_range(0, 99) < 6 || since_redirect > 150)) begin
      pc_redirect = 1'b1;
      pc_target   = 16'($urandom);
      if ($urandom_range(0, 7) == 0) pc_target = 16'hFFFB;
      restart({pc_target[15:1], 1'b0});
      since_redirect = 0;
    end else begin
      since_redirect++;
    end
    if (!imem_read) begin
      age       = 0;
      imem_resp = 1'b0;
    end else begin
      if (age == 0) lat = (phase == 1) ? 1 : int'($urandom_range(1, 4));
      age++;
      imem_resp  = (age >= lat);
      imem_rdata = imem_resp ? mem_word(imem_address) : 16'($urandom);
      if (imem_resp) age = 0;
    end
  endtask

  initial begin : monitor
    bit          prev_open;
    logic [15:0] prev_addr;
    exp_t        e;
    prev_open = 1'b0;
    prev_addr = 16'h0000;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (prev_open) begin
          check("req_hold_read", 16'(imem_read), 16'h0001);
          check("req_hold_addr", imem_address, prev_addr);
        end
        if (!ifid_valid) check("bubble_ir", ifid_ir, 16'h0000);
        if (ifid_valid && !stall && !pc_redirect) begin
          consumed++;
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_empty: got instruction %h with no expected entry", ifid_ir);
          end else begin
            e = sb.pop_front();
            check("ifid_ir", ifid_ir, e.ir);
            check("ifid_pc", ifid_pc, e.pc);
          end
        end
        prev_open = imem_read && !imem_resp;
        prev_addr = imem_address;
      end else begin
        prev_open = 1'b0;
      end
    end
  end

  initial begin : driver
    reset       = 1'b1;
    stall       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 16'h0000;
    imem_resp   = 1'b0;
    imem_rdata  = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    check("rst_imem_read", 16'(imem_read), 16'h0000);
    check("rst_ifid_valid", 16'(ifid_valid), 16'h0000);
    check("rst_ifid_ir", ifid_ir, 16'h0000);
    check("rst_ifid_pc", ifid_pc, 16'h0000);

    @(negedge clk);
    reset = 1'b0;
    restart(16'h0000);
    #1;
    check("first_req_read", 16'(imem_read), 16'h0001);
    check("first_req_addr", imem_address, 16'h0000);
    mon_en   = 1'b1;
    consumed = 0;
    drive_cycle(1);
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      drive_cycle(1);
    end
    #3;
    check("throughput", 16'(consumed), 16'd39);

    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      drive_cycle(2);
    end

    // Asynchronous reset while a request is open must take effect before the next edge.
    @(negedge clk);
    mon_en      = 1'b0;
    stall       = 1'b0;
    pc_redirect = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("async_imem_read", 16'(imem_read), 16'h0000);
    check("async_ifid_valid", 16'(ifid_valid), 16'h0000);
    check("async_ifid_ir", ifid_ir, 16'h0000);
    check("async_ifid_pc", ifid_pc, 16'h0000);
    check("async_imem_addr", imem_address, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
